// File: rtl/sigmoid_arbiter_pkg.sv
// Shared NN definitions: Q3.12 format, sigmoid latency and the
// result tag that follows an operand through the sigmoid pipeline.
package sigmoid_arbiter_pkg;

  localparam int DW = 16;
  localparam int SIG_LAT = 5;
  localparam int ID_W = 4;

  localparam logic [15:0] ONE = 16'h1000;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sigmoid_arbiter_sigmoid.sv
// Shared Q3.12 sigmoid: piecewise-linear (PLAN) approximation,
// LAT register stages from en_i/din_i to valid_o/dout_o.
module sigmoid_arbiter_sigmoid
  import sigmoid_arbiter_pkg::*;
#(
  parameter int DW  = 16,
  parameter int LAT = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          valid_o
);

  localparam logic [DW-1:0] Q_ONE  = DW'(ONE);
  localparam logic [DW-1:0] Q_HALF = DW'(ONE >> 1);
  localparam logic [DW-1:0] X_SAT  = DW'(20480);
  localparam logic [DW-1:0] X_K2   = DW'(9728);
  localparam logic [DW-1:0] X_K1   = DW'(4096);
  localparam logic [DW-1:0] C_K2   = DW'(3456);
  localparam logic [DW-1:0] C_K1   = DW'(2560);

  logic [DW-1:0] mag;
  logic [DW-1:0] pos_y;
  logic [DW-1:0] y;

  logic [DW-1:0] d_q [LAT];
  logic [LAT-1:0] v_q;

  // Evaluate on |x|, then mirror: sig(-x) = 1 - sig(x)
  always_comb begin
    mag = din_i[DW-1] ? (~din_i + DW'(1)) : din_i;
    unique case (1'b1)
      (mag >= X_SAT): pos_y = Q_ONE;
      (mag >= X_K2 && mag < X_SAT): pos_y = (mag >> 5) + C_K2;
      (mag >= X_K1 && mag < X_K2): pos_y = (mag >> 3) + C_K1;
      default: pos_y = ((mag + DW'(8)) >> 2) + Q_HALF;
    endcase
    y = din_i[DW-1] ? (Q_ONE - pos_y) : pos_y;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q[0] <= en_i;
      d_q[0] <= y;
      for (int k = 1; k < LAT; k++) begin
        v_q[k] <= v_q[k-1];
        d_q[k] <= d_q[k-1];
      end
    end
  end

  assign dout_o  = d_q[LAT-1];
  assign valid_o = v_q[LAT-1];

endmodule

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one sigmoid unit among N_REQ LSTM
// gate lanes; results are routed back by a tag riding beside it.
module sigmoid_arbiter
  import sigmoid_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = sigmoid_arbiter_pkg::DW,
  parameter int SIG_LAT = sigmoid_arbiter_pkg::SIG_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                hold,
  output logic [N_REQ-1:0]    res_valid,
  output logic [DW-1:0]       res_data,
  output logic                busy,
  output logic                err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(SIG_LAT + 1);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic          err_q, err_d;
  logic [DW-1:0] res_data_q, res_data_d;
  tag_t          tag_q [SIG_LAT];

  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    gidx;
  logic             found;
  logic             xfer;
  int               idx;

  logic          sig_en;
  logic [DW-1:0] sig_din;
  logic [DW-1:0] sig_dout;
  logic          sig_valid;
  tag_t          tag_in;
  tag_t          tag_out;
  logic          res_fire;
  logic          dec;

  // Search starts just past the last winner
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        gidx  = idx[PW-1:0];
      end
    end
    if (found && !hold && !rst) grant[gidx] = 1'b1;
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign rr_ptr_d  = xfer ? gidx : rr_ptr_q;

  assign sig_en  = xfer & ~rst;
  assign sig_din = xfer ? req_data[gidx*DW +: DW] : '0;

  sigmoid_arbiter_sigmoid #(
    .DW  (DW),
    .LAT (SIG_LAT)
  ) u_sig (
    .clk_i   (clk),
    .rst_ni  (~rst),
    .en_i    (sig_en),
    .din_i   (sig_din),
    .dout_o  (sig_dout),
    .valid_o (sig_valid)
  );

  assign tag_in  = '{valid: xfer, id: ID_W'(gidx)};
  assign tag_out = tag_q[SIG_LAT-1];

  assign res_fire = sig_valid & ~rst;

  always_comb begin
    res_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      res_valid[i] = res_fire && (tag_out.id == ID_W'(i));
    end
  end

  assign res_data_d = res_fire ? sig_dout : res_data_q;
  assign res_data   = res_data_d;

  // Guarded so a spurious sigmoid strobe cannot wrap the counter
  assign dec = sig_valid && (in_flight_q != '0);

  always_comb begin
    in_flight_d = in_flight_q;
    unique case (1'b1)
      (xfer && !dec): in_flight_d = in_flight_q + CW'(1);
      (dec && !xfer): in_flight_d = in_flight_q - CW'(1);
      default:        in_flight_d = in_flight_q;
    endcase
  end

  assign err_d = err_q | (sig_valid != tag_out.valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= PW'(N_REQ - 1);
      in_flight_q <= '0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
      for (int k = 0; k < SIG_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
      res_data_q  <= res_data_d;
      tag_q[0]    <= tag_in;
      for (int k = 1; k < SIG_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign busy = (|req_valid) || (in_flight_q != '0);
  assign err  = err_q;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Scoreboard bench for sigmoid_arbiter: directed lane traffic,
// expected grants/results queued by the stimulus, checked by monitors.
module tb_sigmoid_arbiter;

  typedef struct {
    logic [3:0]  oh;
    logic [15:0] res;
    bit          keep;
  } g_t;

  typedef struct {
    logic [3:0]  oh;
    logic [15:0] res;
    int          due;
  } r_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        hold = 1'b0;
  logic [3:0]  res_valid;
  logic [15:0] res_data;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fire = -100;
  bit mon_en = 1'b1;

  logic [15:0] lane_q [4][$];
  g_t exp_g [$];
  r_t exp_r [$];

  sigmoid_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .res_valid (res_valid),
    .res_data  (res_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic give(int lane, logic [15:0] d);
    lane_q[lane].push_back(d);
  endtask

  task automatic expect_g(int lane, logic [15:0] r, bit keep);
    g_t g;
    g.oh = '0;
    g.oh[lane] = 1'b1;
    g.res = r;
    g.keep = keep;
    exp_g.push_back(g);
  endtask

  // Requester model: drop an operand once it has been accepted
  logic [3:0] fire_d;
  always begin
    @(negedge clk);
    fire_d = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire_d[i] && lane_q[i].size() > 0) lane_q[i].delete(0);
      if (lane_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*16 +: 16] = lane_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*16 +: 16] = '0;
      end
    end
  end

  // Grant monitor
  always @(negedge clk) begin
    logic [3:0] fire;
    g_t e;
    r_t r;
    fire = req_valid & req_ready;
    if (fire != '0) begin
      if (exp_g.size() == 0) begin
        chk("unexp_grant", {28'd0, fire}, 32'd0);
      end else begin
        e = exp_g.pop_front();
        chk("grant", {28'd0, fire}, {28'd0, e.oh});
        last_fire = cyc;
        if (e.keep) begin
          r.oh = e.oh;
          r.res = e.res;
          r.due = cyc + 5;
          exp_r.push_back(r);
        end
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin
    r_t r;
    if (mon_en && res_valid != '0) begin
      if (exp_r.size() == 0) begin
        chk("unexp_res", {28'd0, res_valid}, 32'd0);
      end else begin
        r = exp_r.pop_front();
        chk("res_onehot", {28'd0, res_valid}, {28'd0, r.oh});
        chk("res_data", {16'd0, res_data}, {16'd0, r.res});
        chk("res_cycle", cyc, r.due);
      end
    end
  end

  task automatic wait_drain();
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 200) begin
      pend = (exp_g.size() != 0) || (exp_r.size() != 0);
      for (int i = 0; i < 4; i++) begin
        if (lane_q[i].size() != 0) pend = 1'b1;
      end
      if (pend) begin
        tick();
        n++;
      end
    end
    chk("drain_timeout", n, (n < 200) ? n : 0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_resv", {28'd0, res_valid}, 32'd0);
    chk("rst_resd", {16'd0, res_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rrptr", 32'(dut.rr_ptr_q), 32'd3);
    chk("rst_inflight", 32'(dut.in_flight_q), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // single lane, sigmoid(0)
    give(0, 16'h0000);
    expect_g(0, 16'h0802, 1'b1);
    wait_drain();

    // all lanes together from reset
    do_reset();
    give(0, 16'h0000);
    give(1, 16'h7FFF);
    give(2, 16'h8001);
    give(3, 16'h0000);
    expect_g(0, 16'h0802, 1'b1);
    expect_g(1, 16'h1000, 1'b1);
    expect_g(2, 16'h0000, 1'b1);
    expect_g(3, 16'h0802, 1'b1);
    wait_drain();

    // lanes 1 and 3 streaming: alternate, busy tail of 5 cycles
    do_reset();
    give(1, 16'h1000);
    give(1, 16'h0400);
    give(1, 16'h2800);
    give(3, 16'hF000);
    give(3, 16'h0000);
    give(3, 16'h7FFF);
    expect_g(1, 16'h0C00, 1'b1);
    expect_g(3, 16'h0400, 1'b1);
    expect_g(1, 16'h0902, 1'b1);
    expect_g(3, 16'h0802, 1'b1);
    expect_g(1, 16'h0EC0, 1'b1);
    expect_g(3, 16'h1000, 1'b1);
    repeat (16) begin
      @(negedge clk);
      #1;
      chk("busy", {31'd0, busy},
          {31'd0, (req_valid != '0) || (cyc <= last_fire + 5)});
    end
    wait_drain();

    // hold after three transfers
    do_reset();
    give(0, 16'h1000);
    give(1, 16'hF000);
    give(2, 16'h2800);
    give(3, 16'h0400);
    expect_g(0, 16'h0C00, 1'b1);
    expect_g(1, 16'h0400, 1'b1);
    expect_g(2, 16'h0EC0, 1'b1);
    expect_g(3, 16'h0902, 1'b1);
    repeat (4) tick();
    hold = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("hold_ready", {28'd0, req_ready}, 32'd0);
    end
    chk("hold_inflight", 32'(dut.in_flight_q), 32'd0);
    tick();
    hold = 1'b0;
    wait_drain();

    // reset mid-flight discards results
    do_reset();
    give(0, 16'h0000);
    give(1, 16'h0000);
    expect_g(0, 16'h0000, 1'b0);
    expect_g(1, 16'h0000, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rrptr", 32'(dut.rr_ptr_q), 32'd3);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_inflight", 32'(dut.in_flight_q), 32'd0);
    repeat (8) tick();
    give(2, 16'h2800);
    give(0, 16'h0000);
    expect_g(0, 16'h0802, 1'b1);
    expect_g(2, 16'h0EC0, 1'b1);
    wait_drain();

    // spurious sigmoid valid with empty tag register
    mon_en = 1'b0;
    tick();
    chk("pre_err", {31'd0, err}, 32'd0);
    force dut.sig_valid = 1'b1;
    tick();
    release dut.sig_valid;
    @(negedge clk);
    chk("err_set", {31'd0, err}, 32'd1);
    repeat (5) tick();
    @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    tick();
    mon_en = 1'b1;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
